// File: rtl/if_fetch_buffer_if.sv
// Instruction-memory request/response bus between the fetch buffer (master) and memory (slave).
// Requests are address-only; responses return in request order.
interface if_fetch_buffer_if;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;

   modport master (
      output inst_req,
      output inst_addr,
      input  inst_addr_ok,
      input  inst_data_ok,
      input  inst_rdata
   );

   modport slave (
      input  inst_req,
      input  inst_addr,
      output inst_addr_ok,
      output inst_data_ok,
      output inst_rdata
   );
endinterface

// File: rtl/if_fetch_buffer.sv
// Instruction fetch queue: issues in-order fetches, buffers responses and presents the head
// entry to decode; redirects flush the queue and discard responses still owed to the old path.
module if_fetch_buffer #(
   parameter logic [31:0] RESET_PC = 32'hBFC00000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   if_fetch_buffer_if.master        mem,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   input  logic                     stallD,
   output logic                     validD,
   output logic [31:0]              instrD,
   output logic [31:0]              pcD,
   output logic                     adelD
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam int unsigned DW = 8;

   logic [31:0]   fetch_pc_q;
   logic [PW-1:0] head_q, tail_q;
   logic [CW-1:0] count_q;
   logic [DW-1:0] drop_q;
   logic          adel_done_q;

   logic [31:0]   pc_q    [DEPTH];
   logic [31:0]   instr_q [DEPTH];
   logic          filled_q[DEPTH];
   logic          adel_q  [DEPTH];

   logic          misaligned, not_full, acc_raw, acc, adel_alloc, retire, dok_used;
   logic          fill_found;
   logic [PW-1:0] fill_idx;
   logic [CW-1:0] pending;

   assign misaligned   = fetch_pc_q[1:0] != 2'b00;
   assign not_full     = count_q < CW'(DEPTH);
   assign mem.inst_req  = !rst && !misaligned && not_full;
   assign mem.inst_addr = fetch_pc_q;

   assign validD = (count_q != '0) && filled_q[head_q];
   assign instrD = (count_q != '0) ? instr_q[head_q] : 32'h0;
   assign pcD    = (count_q != '0) ? pc_q[head_q]    : 32'h0;
   assign adelD  = (count_q != '0) && adel_q[head_q];

   assign acc_raw    = mem.inst_req && mem.inst_addr_ok;
   assign acc        = acc_raw && !redirect;
   assign adel_alloc = !redirect && misaligned && not_full && !adel_done_q;
   assign retire     = validD && !stallD && !redirect;
   assign dok_used   = mem.inst_data_ok && ((drop_q != '0) || fill_found);

   // Oldest allocated-but-unfilled entry receives the next response.
   always_comb begin
      logic [PW-1:0] idx;
      idx        = '0;
      fill_found = 1'b0;
      fill_idx   = '0;
      pending    = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         idx = head_q + PW'(i);
         if (CW'(i) < count_q && !filled_q[idx]) begin
            pending = pending + 1'b1;
            if (!fill_found) begin
               fill_found = 1'b1;
               fill_idx   = idx;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q  <= RESET_PC;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         drop_q      <= '0;
         adel_done_q <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            pc_q[i]     <= 32'h0;
            instr_q[i]  <= 32'h0;
            filled_q[i] <= 1'b0;
            adel_q[i]   <= 1'b0;
         end
      end else if (redirect) begin
         // Everything still owed to the old path, including this cycle's acceptance, is dropped.
         drop_q      <= drop_q + DW'(pending) + DW'(acc_raw) - DW'(dok_used);
         fetch_pc_q  <= redirect_pc;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         adel_done_q <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            filled_q[i] <= 1'b0;
         end
      end else begin
         if (mem.inst_data_ok) begin
            if (drop_q != '0) begin
               drop_q <= drop_q - 1'b1;
            end else if (fill_found) begin
               instr_q[fill_idx]  <= mem.inst_rdata;
               filled_q[fill_idx] <= 1'b1;
            end
         end
         if (acc || adel_alloc) begin
            pc_q[tail_q]     <= fetch_pc_q;
            instr_q[tail_q]  <= 32'h0;
            filled_q[tail_q] <= adel_alloc;
            adel_q[tail_q]   <= adel_alloc;
            tail_q           <= tail_q + 1'b1;
         end
         if (acc) begin
            fetch_pc_q <= fetch_pc_q + 32'd4;
         end
         if (adel_alloc) begin
            adel_done_q <= 1'b1;
         end
         if (retire) begin
            head_q <= head_q + 1'b1;
         end
         count_q <= count_q + CW'(acc || adel_alloc) - CW'(retire);
      end
   end

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Bench for if_fetch_buffer: in-order memory model, queue-based reference model checked every
// cycle, and directed scenarios with literal expectations.
module tb_if_fetch_buffer;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'hBFC00000;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      bit          filled;
      bit          adel;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        addr_ok = 1'b0, dok_en = 1'b1, spur = 1'b0;
   logic        redirect = 1'b0, stallD = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        validD, adelD;
   logic [31:0] instrD, pcD;
   logic        mem_has = 1'b0;
   logic [31:0] mem_head = 32'h0;

   int tests = 0;
   int fails = 0;
   int cycle = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   if_fetch_buffer_if bus();

   assign bus.inst_addr_ok = addr_ok;
   assign bus.inst_data_ok = (dok_en && mem_has) || spur;
   assign bus.inst_rdata   = spur ? 32'hDEADBEEF : mem_head;

   if_fetch_buffer #(
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .mem         (bus.master),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .stallD      (stallD),
      .validD      (validD),
      .instrD      (instrD),
      .pcD         (pcD),
      .adelD       (adelD)
   );

   function automatic logic [31:0] memdata(input logic [31:0] a);
      return a ^ 32'h5A5AA5A5;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // In-order memory: one response per cycle, earliest the cycle after acceptance.
   logic [31:0] memq[$];
   logic        req_n = 1'b0;
   logic [31:0] addr_n = 32'h0;
   logic        m_acc, m_pop;
   logic [31:0] m_addr;

   always @(negedge clk) begin
      req_n  = bus.inst_req;
      addr_n = bus.inst_addr;
   end

   always @(posedge clk) begin
      m_acc  = req_n && addr_ok;
      m_addr = addr_n;
      m_pop  = dok_en && mem_has;
      #1;
      if (rst) begin
         memq.delete();
      end else begin
         if (m_pop && memq.size() > 0) void'(memq.pop_front());
         if (m_acc) memq.push_back(memdata(m_addr));
      end
      mem_has  = memq.size() > 0;
      mem_head = mem_has ? memq[0] : 32'h0;
   end

   // Reference model: the queue as a list of entries, plus fetch PC and owed-response count.
   ent_t        mq[$];
   logic [31:0] m_pc = RESET_PC;
   int          m_drop = 0;
   bit          m_adel_done = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_pc        = RESET_PC;
         m_drop      = 0;
         m_adel_done = 0;
      end else begin
         bit   acc, dok, ret;
         int   pend;
         ent_t e;
         acc  = (m_pc[1:0] == 2'b00) && (mq.size() < DEPTH) && addr_ok;
         dok  = bus.inst_data_ok;
         pend = 0;
         foreach (mq[i]) if (!mq[i].filled) pend++;
         if (redirect) begin
            m_drop = m_drop + pend + (acc ? 1 : 0) - ((dok && (m_drop > 0 || pend > 0)) ? 1 : 0);
            mq.delete();
            m_pc        = redirect_pc;
            m_adel_done = 0;
         end else begin
            ret = mq.size() > 0 && mq[0].filled && !stallD;
            if (dok) begin
               if (m_drop > 0) begin
                  m_drop--;
               end else begin
                  for (int i = 0; i < mq.size(); i++) begin
                     if (!mq[i].filled) begin
                        mq[i].filled = 1;
                        mq[i].instr  = bus.inst_rdata;
                        break;
                     end
                  end
               end
            end
            if (acc) begin
               e = '{pc: m_pc, instr: 32'h0, filled: 0, adel: 0};
               mq.push_back(e);
               m_pc = m_pc + 32'd4;
            end else if (m_pc[1:0] != 2'b00 && mq.size() < DEPTH && !m_adel_done) begin
               e = '{pc: m_pc, instr: 32'h0, filled: 1, adel: 1};
               mq.push_back(e);
               m_adel_done = 1;
            end
            if (ret) void'(mq.pop_front());
         end
      end
   end

   // Per-cycle comparison against the model, plus logs for the directed literal checks.
   logic [31:0] acc_log[$];
   ent_t        ret_log[$];
   int          ret_cyc[$];

   always @(negedge clk) begin
      logic exp_req, exp_v;
      ent_t e;
      exp_req = !rst && (m_pc[1:0] == 2'b00) && (mq.size() < DEPTH);
      exp_v   = !rst && mq.size() > 0 && mq[0].filled;
      chk("inst_req", 32'(bus.inst_req), 32'(exp_req));
      if (exp_req) chk("inst_addr", bus.inst_addr, m_pc);
      chk("validD", 32'(validD), 32'(exp_v));
      if (rst) begin
         chk("rst_instrD", instrD, 32'h0);
         chk("rst_pcD", pcD, 32'h0);
         chk("rst_adelD", 32'(adelD), 32'h0);
      end else if (exp_v) begin
         chk("pcD", pcD, mq[0].pc);
         chk("adelD", 32'(adelD), 32'(mq[0].adel));
         chk("instrD", instrD, mq[0].instr);
         chk("instr_vs_mem", instrD, mq[0].adel ? 32'h0 : memdata(mq[0].pc));
      end
      if (!rst) begin
         if (bus.inst_req && addr_ok) acc_log.push_back(bus.inst_addr);
         if (validD && !stallD && !redirect) begin
            e = '{pc: pcD, instr: instrD, filled: 1, adel: adelD};
            ret_log.push_back(e);
            ret_cyc.push_back(cycle);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      acc_log.delete();
      ret_log.delete();
      ret_cyc.delete();
   endtask

   task automatic do_redirect(input logic [31:0] pc);
      redirect    = 1'b1;
      redirect_pc = pc;
      cyc(1);
      redirect = 1'b0;
      clear_logs();
   endtask

   initial begin
      cyc(3);
      chk("rst_validD", 32'(validD), 32'h0);
      rst     = 1'b0;
      addr_ok = 1'b1;
      clear_logs();

      // Streaming from reset.
      cyc(10);
      chk("t1_nacc", 32'(acc_log.size() >= 2), 32'h1);
      if (acc_log.size() >= 2) chk("t1_first_addr", acc_log[0], 32'hBFC00000);
      chk("t1_nret", 32'(ret_log.size() >= 3), 32'h1);
      if (ret_log.size() >= 3) begin
         chk("t1_pc0", ret_log[0].pc, 32'hBFC00000);
         chk("t1_pc1", ret_log[1].pc, 32'hBFC00004);
         chk("t1_pc2", ret_log[2].pc, 32'hBFC00008);
         chk("t1_consec1", 32'(ret_cyc[1] - ret_cyc[0]), 32'd1);
         chk("t1_consec2", 32'(ret_cyc[2] - ret_cyc[1]), 32'd1);
      end

      // Backpressure: full queue stops requests; release retires in order.
      stallD = 1'b1;
      do_redirect(32'h00001000);
      cyc(10);
      chk("t2_nacc", 32'(acc_log.size()), 32'd4);
      chk("t2_req_full", 32'(bus.inst_req), 32'h0);
      chk("t2_nret_stalled", 32'(ret_log.size()), 32'd0);
      stallD = 1'b0;
      cyc(8);
      chk("t2_nret", 32'(ret_log.size() >= 4), 32'h1);
      if (ret_log.size() >= 4) begin
         chk("t2_pc0", ret_log[0].pc, 32'h00001000);
         chk("t2_pc1", ret_log[1].pc, 32'h00001004);
         chk("t2_pc2", ret_log[2].pc, 32'h00001008);
         chk("t2_pc3", ret_log[3].pc, 32'h0000100C);
      end

      // Redirect with two responses outstanding.
      addr_ok = 1'b0;
      cyc(6);
      dok_en  = 1'b0;
      addr_ok = 1'b1;
      cyc(2);
      addr_ok = 1'b0;
      do_redirect(32'h80000100);
      addr_ok = 1'b1;
      dok_en  = 1'b1;
      cyc(8);
      chk("t3_nret", 32'(ret_log.size() >= 1), 32'h1);
      if (ret_log.size() >= 1) begin
         chk("t3_pc", ret_log[0].pc, 32'h80000100);
         chk("t3_instr", ret_log[0].instr, 32'hDA5AA4A5);
      end

      // Misaligned redirect target.
      do_redirect(32'h80000102);
      cyc(6);
      chk("t4_req", 32'(bus.inst_req), 32'h0);
      chk("t4_nacc", 32'(acc_log.size()), 32'd0);
      chk("t4_nret", 32'(ret_log.size()), 32'd1);
      if (ret_log.size() >= 1) begin
         chk("t4_pc", ret_log[0].pc, 32'h80000102);
         chk("t4_adel", 32'(ret_log[0].adel), 32'h1);
         chk("t4_instr", ret_log[0].instr, 32'h0);
      end

      // Fetch PC wraps modulo 2^32.
      do_redirect(32'hFFFFFFFC);
      cyc(4);
      chk("t5_nacc", 32'(acc_log.size() >= 2), 32'h1);
      if (acc_log.size() >= 2) begin
         chk("t5_addr0", acc_log[0], 32'hFFFFFFFC);
         chk("t5_addr1", acc_log[1], 32'h00000000);
      end

      // Reset while the queue holds three entries.
      stallD = 1'b1;
      do_redirect(32'h00003000);
      cyc(3);
      addr_ok = 1'b0;
      cyc(4);
      chk("t6_valid_before", 32'(validD), 32'h1);
      chk("t6_pc_before", pcD, 32'h00003000);
      rst = 1'b1;
      #1;
      chk("t6_valid_rst", 32'(validD), 32'h0);
      chk("t6_req_rst", 32'(bus.inst_req), 32'h0);
      cyc(2);
      rst     = 1'b0;
      stallD  = 1'b0;
      addr_ok = 1'b1;
      clear_logs();
      cyc(3);
      chk("t6_nacc", 32'(acc_log.size() >= 1), 32'h1);
      if (acc_log.size() >= 1) chk("t6_first_addr", acc_log[0], 32'hBFC00000);

      // Stray response with nothing awaiting data is ignored.
      addr_ok = 1'b0;
      cyc(6);
      spur = 1'b1;
      cyc(1);
      spur = 1'b0;
      cyc(2);
      chk("t7_valid", 32'(validD), 32'h0);
      addr_ok = 1'b1;
      clear_logs();
      cyc(6);
      chk("t7_nret", 32'(ret_log.size() >= 2), 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/if_fetch_buffer.md
IF_FETCH_BUFFER -- requirements
Module: if_fetch_buffer

Interface
REQ-001 Parameter RESET_PC, 32'hBFC00000, PC of first fetch after reset SHALL be this value.
REQ-002 Parameter DEPTH, 4, entry count of the fetch queue; SHALL be a power of two, 2..8.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 inst_req  out  1  fetch request to instruction memory.
REQ-006 inst_addr  out  32  word address of the request.
REQ-007 inst_addr_ok  in  1  memory accepts the request this cycle.
REQ-008 inst_data_ok  in  1  one in-order read response this cycle.
REQ-009 inst_rdata  in  32  response data, valid with inst_data_ok.
REQ-010 redirect  in  1  branch/jump/exception redirect, one-cycle pulse.
REQ-011 redirect_pc  in  32  new fetch PC, valid with redirect.
REQ-012 stallD  in  1  decode cannot accept the head instruction.
REQ-013 validD  out  1  instrD/pcD/adelD hold a valid instruction.
REQ-014 instrD  out  32  instruction word presented to the decode controller.
REQ-015 pcD  out  32  PC of instrD.
REQ-016 adelD  out  1  fetch address error (PC[1:0] != 0); instrD SHALL be 0 when set.

Function
REQ-017 Queue entry SHALL hold {pc, instr, filled, adel}; it is allocated when its request is accepted and filled when its response arrives.
REQ-018 inst_req SHALL be 1 iff not in reset, fetch PC[1:0]==0, and queue occupancy < DEPTH.
REQ-019 inst_addr SHALL equal the fetch PC whenever inst_req is 1.
REQ-020 On inst_req & inst_addr_ok (and no redirect), the unit SHALL allocate the tail entry and advance the fetch PC by 4, modulo 2^32.
REQ-021 Responses SHALL fill allocated-but-unfilled entries in allocation order.
REQ-022 If fetch PC[1:0] != 0 and occupancy < DEPTH, the unit SHALL allocate one entry with adel=1, filled=1, instr=0, issue no request, and hold the fetch PC until a redirect arrives.
REQ-023 validD SHALL equal head entry filled; instrD/pcD/adelD SHALL show the head entry.
REQ-024 The head SHALL retire when validD & !stallD; retire and allocate in the same cycle SHALL leave occupancy unchanged.
REQ-025 A full queue SHALL hold inst_req at 0; a same-cycle retire SHALL NOT enable a same-cycle request.
REQ-026 On redirect: all entries SHALL be discarded, validD SHALL be 0 next cycle, the fetch PC SHALL become redirect_pc, and any same-cycle retire or address acceptance SHALL be cancelled.
REQ-027 A drop counter SHALL record responses owed to discarded requests, including one accepted in the redirect cycle; while it is nonzero, each inst_data_ok SHALL decrement it and its data SHALL be discarded.
REQ-028 The first post-redirect request SHALL be issued the cycle after redirect, independent of the drop counter.
REQ-029 inst_data_ok with no entry awaiting data and drop counter 0 SHALL be ignored.
REQ-030 Latency: a response at cycle N SHALL make the entry visible on validD at N+1 if it is the head.

Reset
REQ-031 While rst is 1: fetch PC=RESET_PC, queue empty, drop counter 0, inst_req=0, validD=0, instrD=0, pcD=0, adelD=0.
REQ-032 Deassertion of rst SHALL allow inst_req=1 with inst_addr=RESET_PC on the next rising edge.
REQ-033 Reset asserted mid-operation SHALL discard all entries and pending responses without producing validD.

Verification
REQ-034 Streaming: addr_ok and data_ok always 1 one cycle later, stallD=0 -> validD stream with pcD BFC00000, BFC00004, BFC00008 on consecutive cycles.
REQ-035 Backpressure: stallD=1 for 10 cycles, memory always ready -> exactly DEPTH=4 requests issued, then inst_req=0; on release, 4 instructions retire in order.
REQ-036 Redirect with 2 outstanding: redirect_pc=0x80000100 -> next 2 responses dropped; first validD shows pcD=0x80000100 with new data.
REQ-037 Misaligned redirect_pc=0x80000102 -> no inst_req; validD=1, adelD=1, instrD=0, pcD=0x80000102; fetch PC held until the next redirect.
REQ-038 Reset asserted while the queue holds 3 entries -> validD=0 immediately; after release, first inst_addr=BFC00000.
REQ-039 Wrap: redirect_pc=0xFFFFFFFC -> next requests use 0xFFFFFFFC, then 0x00000000.
